noc_credit_tx: RTL and testbench

Credit-based flit injector sitting at the opposite end of a router input port from the router itself. It accepts 16-bit flits from a local host, buffers them, and drives the router's `valid_i`/`data_i` pair only while it holds credits. It consumes the router's one-cycle `credit_o` pulses to track free router buffer slots. One instance per network-interface injection port.

---
 rtl/noc_pkg.sv | 21 ++
 rtl/noc_tx_fifo.sv | 62 ++++++
 rtl/noc_credit_tx.sv | 149 ++++++++++++++
 tb/tb_noc_credit_tx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg
// Shared types for the network-interface injection path: the flit width,
// the buffered flit entry (tail marker plus payload) and the packet-tracking
// state used by the credit injector.
package noc_pkg;

  localparam int FLIT_W = 16;

  // One buffered flit: the tail marker travels with the payload so the send
  // side knows when a packet ends without any extra sideband state.
  typedef struct packed {
    logic              last;
    logic [FLIT_W-1:0] data;
  } flit_t;

  typedef enum logic {
    PKT_IDLE,
    PKT_BODY
  } pkt_state_t;

endpackage

// File: rtl/noc_tx_fifo.sv
// noc_tx_fifo
// Synchronous FIFO of flit_t entries sitting between the host handshake and
// the credit-gated send logic.
// Ports:
//   i_clk    clock, all logic on posedge
//   i_rstN   synchronous active-low reset, empties the FIFO
//   i_push   write i_data this edge (ignored when full)
//   i_data   flit to write
//   i_pop    drop the head entry this edge (ignored when empty)
//   o_full   no free entry
//   o_empty  no valid entry
//   o_head   oldest entry, valid whenever o_empty is 0
module noc_tx_fifo
  import noc_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic  i_clk,
  input  logic  i_rstN,
  input  logic  i_push,
  input  flit_t i_data,
  input  logic  i_pop,
  output logic  o_full,
  output logic  o_empty,
  output flit_t o_head
);

  localparam int AW = $clog2(DEPTH);

  flit_t          r_mem [DEPTH];
  logic  [AW:0]   r_wrPtr;
  logic  [AW:0]   r_rdPtr;
  logic           w_doPush;
  logic           w_doPop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the index bits match.
  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                    (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_head   = r_mem[r_rdPtr[AW-1:0]];

  // Pointer update; a simultaneous push and pop advances both, leaving
  // occupancy unchanged.
  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + (AW+1)'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only read once the pointers say so.
  always_ff @(posedge i_clk) begin
    if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/noc_credit_tx.sv
// noc_credit_tx
// Credit-based flit injector for one router input port. Host flits are
// buffered locally and forwarded to the router only while a free router
// buffer slot (credit) is known to exist.
// Ports:
//   clk          clock, all logic on posedge
//   rst          synchronous active-low reset
//   host_valid   host offers a flit
//   host_data    host flit payload
//   host_last    flit is the packet tail
//   host_ready   flit can be taken this cycle (0 while full or in reset)
//   valid_o      flit valid toward router valid_i
//   data_o       flit toward router data_i, holds when valid_o is 0
//   credit_i     one-cycle credit return from router credit_o
//   credits_o    current credit count
//   pkt_sent_o   pulse in the cycle valid_o shows a tail flit
//   err_o        sticky credit-overflow error
module noc_credit_tx
  import noc_pkg::*;
#(
  parameter int CREDITS    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         host_valid,
  input  logic [FLIT_W-1:0]            host_data,
  input  logic                         host_last,
  output logic                         host_ready,
  output logic                         valid_o,
  output logic [FLIT_W-1:0]            data_o,
  input  logic                         credit_i,
  output logic [$clog2(CREDITS+1)-1:0] credits_o,
  output logic                         pkt_sent_o,
  output logic                         err_o
);

  localparam int            CW          = $clog2(CREDITS+1);
  localparam logic [CW-1:0] MAX_CREDITS = CW'(CREDITS);

  logic              w_full;
  logic              w_empty;
  flit_t             w_head;
  flit_t             w_hostFlit;
  logic              w_push;
  logic              w_send;
  logic              w_tailSent;
  logic              w_overflow;
  logic [CW-1:0]     w_nextCredits;
  pkt_state_t        r_state;
  pkt_state_t        w_nextState;
  logic [CW-1:0]     r_credits;
  logic              r_valid;
  logic [FLIT_W-1:0] r_data;
  logic              r_pktSent;
  logic              r_err;

  // host_ready is held low during reset so nothing is taken into a FIFO
  // that is being cleared.
  assign host_ready = rst && !w_full;
  assign w_push     = host_valid && host_ready;
  assign w_hostFlit = '{last: host_last, data: host_data};

  // A send needs both a buffered flit and a known free router slot.
  assign w_send = !w_empty && (r_credits != '0);

  noc_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rstN  (rst),
    .i_push  (w_push),
    .i_data  (w_hostFlit),
    .i_pop   (w_send),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // Credit arithmetic: a return and a send in the same cycle cancel. A
  // return with the count already at maximum means the router handed back
  // a slot it never had; the count saturates and the error is flagged.
  always_comb begin
    w_nextCredits = r_credits;
    w_overflow    = 1'b0;
    case ({credit_i, w_send})
      2'b10: begin
        if (r_credits == MAX_CREDITS) w_overflow = 1'b1;
        else                          w_nextCredits = r_credits + CW'(1);
      end
      2'b01:   w_nextCredits = r_credits - CW'(1);
      default: w_nextCredits = r_credits;
    endcase
  end

  // Credit counter and sticky error register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_credits <= MAX_CREDITS;
      r_err     <= 1'b0;
    end else begin
      r_credits <= w_nextCredits;
      if (w_overflow) r_err <= 1'b1;
    end
  end

  // Packet FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= PKT_IDLE;
    else      r_state <= w_nextState;
  end

  // Packet FSM next state: a single-flit packet (tail sent from IDLE)
  // never enters BODY. Every tail send raises the packet-sent pulse.
  always_comb begin
    w_nextState = r_state;
    w_tailSent  = 1'b0;
    case (r_state)
      PKT_IDLE: begin
        if (w_send && !w_head.last) w_nextState = PKT_BODY;
      end
      PKT_BODY: begin
        if (w_send && w_head.last) w_nextState = PKT_IDLE;
      end
      default: w_nextState = PKT_IDLE;
    endcase
    if (w_send && w_head.last) w_tailSent = 1'b1;
  end

  // Router-side output registers; data holds its last value between sends.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_pktSent <= 1'b0;
    end else begin
      r_valid   <= w_send;
      r_pktSent <= w_tailSent;
      if (w_send) r_data <= w_head.data;
    end
  end

  assign valid_o    = r_valid;
  assign data_o     = r_data;
  assign pkt_sent_o = r_pktSent;
  assign credits_o  = r_credits;
  assign err_o      = r_err;

endmodule

// File: tb/tb_noc_credit_tx.sv
// tb_noc_credit_tx
// Directed bench for noc_credit_tx. Every accepted host flit is queued as
// the expected router-side flit; whenever valid_o is seen the head of the
// queue is compared against data_o and pkt_sent_o.
module tb_noc_credit_tx;
  import noc_pkg::*;

  logic              clk;
  logic              rst;
  logic              host_valid;
  logic [FLIT_W-1:0] host_data;
  logic              host_last;
  logic              host_ready;
  logic              valid_o;
  logic [FLIT_W-1:0] data_o;
  logic              credit_i;
  logic [2:0]        credits_o;
  logic              pkt_sent_o;
  logic              err_o;

  int    errors = 0;
  int    checks = 0;
  int    validSeen;
  int    accepted;
  flit_t sbQueue[$];

  noc_credit_tx #(
    .CREDITS    (4),
    .FIFO_DEPTH (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .host_valid (host_valid),
    .host_data  (host_data),
    .host_last  (host_last),
    .host_ready (host_ready),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .credit_i   (credit_i),
    .credits_o  (credits_o),
    .pkt_sent_o (pkt_sent_o),
    .err_o      (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison point.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: any flit on valid_o must be the oldest accepted one.
  task automatic checkOutput();
    flit_t f;
    if (valid_o === 1'b1) begin
      validSeen++;
      if (sbQueue.size() == 0) begin
        check("unexpected_valid", 32'(valid_o), 32'(0));
      end else begin
        f = sbQueue.pop_front();
        check("data_o", 32'(data_o), 32'(f.data));
        check("pkt_sent_o", 32'(pkt_sent_o), 32'(f.last));
      end
    end else begin
      check("pkt_sent_idle", 32'(pkt_sent_o), 32'(0));
    end
  endtask

  // Drive one cycle of inputs; an offer seen with host_ready high is
  // accepted at the coming edge, so it is queued now.
  task automatic applyStimulus(input logic hv, input logic [15:0] hd,
                               input logic hl, input logic cr);
    flit_t f;
    host_valid = hv;
    host_data  = hd;
    host_last  = hl;
    credit_i   = cr;
    if (hv && host_ready) begin
      f.last = hl;
      f.data = hd;
      sbQueue.push_back(f);
    end
    @(posedge clk);
    #1;
    host_valid = 1'b0;
    credit_i   = 1'b0;
    checkOutput();
  endtask

  task automatic resetDut();
    rst        = 1'b0;
    host_valid = 1'b0;
    credit_i   = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    sbQueue.delete();
    check("rst_valid", 32'(valid_o), 32'(0));
    check("rst_data", 32'(data_o), 32'(0));
    check("rst_credits", 32'(credits_o), 32'(4));
    check("rst_pkt_sent", 32'(pkt_sent_o), 32'(0));
    check("rst_err", 32'(err_o), 32'(0));
    check("rst_host_ready", 32'(host_ready), 32'(0));
    rst = 1'b1;
    #1;
    check("rel_host_ready", 32'(host_ready), 32'(1));
  endtask

  initial begin
    host_data = '0;
    host_last = 1'b0;
    validSeen = 0;
    accepted  = 0;

    $display("[TB] reset values");
    resetDut();

    $display("[TB] basic send");
    applyStimulus(1'b1, 16'hA5A5, 1'b1, 1'b0);
    check("basic_not_yet", 32'(valid_o), 32'(0));
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    check("basic_valid", 32'(valid_o), 32'(1));
    check("basic_credits", 32'(credits_o), 32'(3));
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    check("basic_valid_drop", 32'(valid_o), 32'(0));
    check("basic_credit_back", 32'(credits_o), 32'(4));

    $display("[TB] credit exhaustion");
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b1, 16'(i), (i == 6), 1'b0);
      check("exh_valid", 32'(valid_o), 32'((i >= 2) && (i <= 5)));
    end
    repeat (2) begin
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
      check("exh_stall", 32'(valid_o), 32'(0));
    end
    check("exh_credits", 32'(credits_o), 32'(0));
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    check("ret_valid_early", 32'(valid_o), 32'(0));
    check("ret_credits", 32'(credits_o), 32'(1));
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    check("ret_valid", 32'(valid_o), 32'(1));
    check("ret_data5", 32'(data_o), 32'(5));
    check("ret_credits_used", 32'(credits_o), 32'(0));

    $display("[TB] simultaneous send and return");
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    check("sim_pre_credits", 32'(credits_o), 32'(1));
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    check("sim_valid", 32'(valid_o), 32'(1));
    check("sim_credits", 32'(credits_o), 32'(1));
    repeat (3) applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    check("sim_refill", 32'(credits_o), 32'(4));
    check("sim_sb_empty", 32'(sbQueue.size()), 32'(0));

    $display("[TB] backpressure");
    for (int i = 0; i < 20 && host_ready; i++) begin
      applyStimulus(1'b1, 16'h0100 + 16'(i), ((i % 4) == 3), 1'b0);
      accepted++;
    end
    check("bp_accepted", 32'(accepted), 32'(12));
    check("bp_host_ready", 32'(host_ready), 32'(0));
    check("bp_credits", 32'(credits_o), 32'(0));
    validSeen = 0;
    repeat (4) applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    check("bp_ready_back", 32'(host_ready), 32'(1));
    repeat (3) applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    check("bp_sent4", 32'(validSeen), 32'(4));
    check("bp_credits_spent", 32'(credits_o), 32'(0));
    repeat (4) applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    check("bp_drained", 32'(sbQueue.size()), 32'(0));
    repeat (4) applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    check("bp_refill", 32'(credits_o), 32'(4));
    check("bp_no_err", 32'(err_o), 32'(0));

    $display("[TB] credit overflow");
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    check("ovf_credits", 32'(credits_o), 32'(4));
    check("ovf_err", 32'(err_o), 32'(1));
    repeat (3) applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    check("ovf_sticky", 32'(err_o), 32'(1));

    $display("[TB] reset mid-packet");
    applyStimulus(1'b1, 16'h0201, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0202, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0203, 1'b1, 1'b0);
    resetDut();
    applyStimulus(1'b1, 16'hBEEF, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    check("post_rst_valid", 32'(valid_o), 32'(1));
    check("post_rst_credits", 32'(credits_o), 32'(3));
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    check("post_rst_sb_empty", 32'(sbQueue.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
